nios_nios2_cpu_debug_mem_sequencer: RTL and testbench
=====================================================

Name: nios_nios2_cpu_debug_mem_sequencer

Overview:
- Sequences JTAG debug memory accesses in the clk domain.
- Consumes the jdo word and the ocimem take_action strobes produced by the debug-slave sysclk stage.
- Runs single-word reads and writes on an Avalon-MM style master port into the OCI debug RAM/registers.
- Returns MonDReg, monitor_ready and monitor_error to the debug-slave TCK stage, and auto-increments the word address so the host can stream transfers.

Parameters:
- ADDR_W, 8: word-address width of the memory port.
- TIMEOUT, 255: maximum cycles in any bus-access state before abort. Range 1..2^16-1.
- TMO_W, 16: timeout counter width; must satisfy 2^TMO_W > TIMEOUT.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- jdo  in  38  debug data word from the sysclk stage; valid in the strobe cycle only.
- take_action_ocimem_a  in  1  strobe: load address / optional read / optional error clear.
- take_no_action_ocimem_a  in  1  strobe: read at current address, then increment.
- take_action_ocimem_b  in  1  strobe: write jdo[34:3] at current address, then increment.
- mem_address  out  ADDR_W  word address.
- mem_read  out  1  read command.
- mem_write  out  1  write command.
- mem_writedata  out  32  write data.
- mem_readdata  in  32  read data.
- mem_waitrequest  in  1  slave stall.
- mem_readdatavalid  in  1  read data valid.
- MonDReg  out  32  last read data.
- monitor_ready  out  1  last command complete.
- monitor_error  out  1  sticky error flag.
- busy  out  1  FSM not in IDLE, or pending slot full.

Behaviour:
- Reset values:
  - address register 0; MonDReg 0; monitor_ready 1; monitor_error 0; mem_read 0; mem_write 0; mem_writedata 0; busy 0.
  - FSM to IDLE; pending slot empty; timeout counter 0.
- Command decode (from jdo captured in the strobe cycle):
  - ocimem_a: addr <= jdo[ADDR_W+16:17]; jdo[34]=1 issues a read at the new address; jdo[33]=1 clears monitor_error.
  - no_action_ocimem_a: read at addr.
  - ocimem_b: write data jdo[34:3].
- Simultaneous strobes: priority ocimem_b > ocimem_a > no_action. Lower-priority strobes in the same cycle are ignored.
- FSM states and transitions:
  - IDLE: on a command (fresh or pending), monitor_ready <= 0.
    - Read -> RD_CMD. Write -> WR_CMD.
    - Address-only ocimem_a -> stays IDLE; monitor_ready stays/returns 1 next cycle.
  - RD_CMD: mem_read=1, mem_address=addr, held until mem_waitrequest=0, then -> RD_DATA.
  - RD_DATA: on mem_readdatavalid: MonDReg <= mem_readdata; addr <= addr+1; monitor_ready <= 1; -> IDLE.
  - WR_CMD: mem_write=1 with mem_writedata, held until mem_waitrequest=0; then addr <= addr+1; monitor_ready <= 1; -> IDLE.
- Latency:
  - Strobe in cycle N -> mem_read/mem_write first asserted in N+1 (registered outputs).
  - Zero-wait write: monitor_ready=1 in N+2.
  - Zero-wait read with readdatavalid in N+2: MonDReg and monitor_ready valid in N+3.
- Address increment: wraps modulo 2^ADDR_W (all-ones -> 0), no error.
- Timeout:
  - Counter clears on entering RD_CMD or WR_CMD and is not cleared between RD_CMD and RD_DATA.
  - It increments each cycle spent in RD_CMD, RD_DATA or WR_CMD.
  - On reaching TIMEOUT: deassert mem_read/mem_write; monitor_error <= 1; monitor_ready <= 1; MonDReg and addr unchanged; -> IDLE.
  - A late readdatavalid arriving in IDLE is ignored.
- Pending slot (one entry):
  - A strobe arriving while not IDLE is stored (command type + jdo).
  - It is served in the first IDLE cycle, before any new strobe.
  - A strobe arriving while the slot is full is dropped and sets monitor_error.
  - A strobe in the same cycle the FSM returns to IDLE goes to the slot only if the slot is already full; otherwise it is served directly.
- monitor_error: sticky. Cleared only by reset or by ocimem_a with jdo[33]=1. If an error event and a clear occur in the same cycle, the set wins.
- Reset mid-operation: asynchronous. All outputs return to reset values immediately; the in-flight bus command is abandoned.

Decomposition:
- Shared package nios_nios2_cpu_debug_pkg:
  - FSM state enum: IDLE, RD_CMD, RD_DATA, WR_CMD.
  - Command enum: NONE, LOAD, READ, WRITE.
  - jdo field positions: JDO_ADDR_LSB=17, JDO_RDEN=34, JDO_ERRCLR=33, JDO_WDATA_LSB=3.
- Sub-module nios_nios2_cpu_debug_cmd_slot: one-entry pending holder with overflow flag.

Test Plan:
- Write, then read back (zero-wait slave):
  - ocimem_a jdo addr=0x10, rd=0; ocimem_b data 0xCAFEF00D -> write at 0x10; monitor_ready 1 at N+2; addr=0x11.
  - ocimem_a addr=0x10 rd=1 -> MonDReg=0xCAFEF00D at N+3.
- Streaming reads with wrap: addr=0xFF, two no_action strobes -> reads at 0xFF then 0x00; addr ends 0x01.
- Waitrequest stall: slave holds waitrequest 5 cycles -> mem_write held stable 6 cycles; exactly one write accepted.
- Timeout: TIMEOUT=8, readdatavalid never asserts -> abort after 8 cycles; monitor_error=1, MonDReg unchanged. ocimem_a jdo[33]=1 -> error 0.
- Pending and overflow: three strobes during a stalled read -> second served after the first completes; third dropped; monitor_error=1.
- Async reset mid-read: reset_n low while in RD_DATA -> mem_read 0, monitor_ready 1, addr 0 with no clock edge.

Source files
------------

// File: rtl/nios_nios2_cpu_debug_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nios_nios2_cpu_debug_pkg
//  Description : Shared types and constants for the JTAG debug memory
//                sequencer: FSM state codes, command kinds, jdo field layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package nios_nios2_cpu_debug_pkg;

    // Sequencer FSM state codes
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_CMD  = 2'd1;
    localparam logic [1:0] RD_DATA = 2'd2;
    localparam logic [1:0] WR_CMD  = 2'd3;

    // Command kinds: LOAD = ocimem_a, READ = no_action_ocimem_a, WRITE = ocimem_b
    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_READ  = 2'd2,
        CMD_WRITE = 2'd3
    } cmd_e;

    // jdo field positions
    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_RDEN      = 34;
    localparam int JDO_ERRCLR    = 33;
    localparam int JDO_WDATA_LSB = 3;

    // Strobe priority: ocimem_b > ocimem_a > no_action
    function automatic cmd_e decode_strobes(input logic b, input logic a, input logic n);
        if (b) return CMD_WRITE;
        if (a) return CMD_LOAD;
        if (n) return CMD_READ;
        return CMD_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nios_nios2_cpu_debug_cmd_slot.sv
`default_nettype none
// ============================================================================
//  Module      : nios_nios2_cpu_debug_cmd_slot
//  Description : One-entry holder for a debug command that arrives while the
//                sequencer is busy. A push into a full slot that is not being
//                emptied in the same cycle is dropped and flagged as overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module nios_nios2_cpu_debug_cmd_slot
    import nios_nios2_cpu_debug_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  cmd_e             push_cmd,
    input  logic [JDO_W-1:0] push_jdo,
    input  logic             pop,
    output logic             full,
    output cmd_e             cmd,
    output logic [JDO_W-1:0] data,
    output logic             overflow
);

    assign overflow = push && full && !pop;

    // Hold one command; a simultaneous pop and push refills the slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= 1'b0;
            cmd  <= CMD_NONE;
            data <= '0;
        end else if (push && (!full || pop)) begin
            full <= 1'b1;
            cmd  <= push_cmd;
            data <= push_jdo;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nios_nios2_cpu_debug_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : nios_nios2_cpu_debug_mem_sequencer
//  Description : Turns debug-slave ocimem strobes into single-word Avalon-MM
//                reads/writes, with address auto-increment, bus timeout and a
//                one-entry pending command slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module nios_nios2_cpu_debug_mem_sequencer
    import nios_nios2_cpu_debug_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    input  logic              mem_readdatavalid,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [TMO_W-1:0]  tmo;

    cmd_e              fresh_cmd;
    logic              fresh_valid;
    logic              slot_full;
    logic              slot_push;
    logic              slot_pop;
    logic              slot_ovf;
    cmd_e              slot_cmd;
    logic [JDO_W-1:0]  slot_jdo;
    cmd_e              serve_cmd;
    logic [JDO_W-1:0]  serve_jdo;
    logic              tmo_hit;
    logic              abort;
    logic              err_set;
    logic              err_clr;
    logic              unused_jdo;

    assign fresh_cmd   = decode_strobes(take_action_ocimem_b, take_action_ocimem_a,
                                        take_no_action_ocimem_a);
    assign fresh_valid = (fresh_cmd != CMD_NONE);
    assign mem_address = addr;
    assign busy        = (state != IDLE) || slot_full;
    assign unused_jdo  = ^{serve_jdo[JDO_W-1:JDO_RDEN+1], serve_jdo[JDO_WDATA_LSB-1:0]};

    // Choose what IDLE serves: a pending command first (a new strobe then
    // refills the slot), otherwise the new strobe; while busy, strobes park
    always_comb begin
        serve_cmd = CMD_NONE;
        serve_jdo = jdo;
        slot_push = 1'b0;
        slot_pop  = 1'b0;
        if (state == IDLE) begin
            if (slot_full) begin
                serve_cmd = slot_cmd;
                serve_jdo = slot_jdo;
                slot_pop  = 1'b1;
                slot_push = fresh_valid;
            end else begin
                serve_cmd = fresh_cmd;
            end
        end else begin
            slot_push = fresh_valid;
        end
    end

    nios_nios2_cpu_debug_cmd_slot u_slot (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (slot_push),
        .push_cmd (fresh_cmd),
        .push_jdo (jdo),
        .pop      (slot_pop),
        .full     (slot_full),
        .cmd      (slot_cmd),
        .data     (slot_jdo),
        .overflow (slot_ovf)
    );

    // The counter value seen in the TIMEOUT-th bus cycle is TIMEOUT-1
    assign tmo_hit = (tmo >= TMO_W'(TIMEOUT - 1));
    assign abort   = tmo_hit && (((state == RD_CMD)  && mem_waitrequest)   ||
                                 ((state == RD_DATA) && !mem_readdatavalid) ||
                                 ((state == WR_CMD)  && mem_waitrequest));
    assign err_set = slot_ovf || abort;
    assign err_clr = (serve_cmd == CMD_LOAD) && serve_jdo[JDO_ERRCLR];

    // Command sequencing and bus handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            addr          <= '0;
            tmo           <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    case (serve_cmd)
                        CMD_LOAD: begin
                            addr <= serve_jdo[ADDR_W+JDO_ADDR_LSB-1:JDO_ADDR_LSB];
                            if (serve_jdo[JDO_RDEN]) begin
                                mem_read      <= 1'b1;
                                monitor_ready <= 1'b0;
                                tmo           <= '0;
                                state         <= RD_CMD;
                            end else begin
                                monitor_ready <= 1'b1;
                            end
                        end
                        CMD_READ: begin
                            mem_read      <= 1'b1;
                            monitor_ready <= 1'b0;
                            tmo           <= '0;
                            state         <= RD_CMD;
                        end
                        CMD_WRITE: begin
                            mem_write     <= 1'b1;
                            mem_writedata <= serve_jdo[JDO_WDATA_LSB+31:JDO_WDATA_LSB];
                            monitor_ready <= 1'b0;
                            tmo           <= '0;
                            state         <= WR_CMD;
                        end
                        default: ;
                    endcase
                end
                RD_CMD: begin
                    if (!mem_waitrequest) begin
                        mem_read <= 1'b0;
                        tmo      <= tmo + 1'b1;
                        state    <= RD_DATA;
                    end else if (abort) begin
                        mem_read      <= 1'b0;
                        monitor_ready <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                RD_DATA: begin
                    if (mem_readdatavalid) begin
                        MonDReg       <= mem_readdata;
                        addr          <= addr + 1'b1;
                        monitor_ready <= 1'b1;
                        state         <= IDLE;
                    end else if (abort) begin
                        monitor_ready <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                WR_CMD: begin
                    if (!mem_waitrequest) begin
                        mem_write     <= 1'b0;
                        addr          <= addr + 1'b1;
                        monitor_ready <= 1'b1;
                        state         <= IDLE;
                    end else if (abort) begin
                        mem_write     <= 1'b0;
                        monitor_ready <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error; a set in the same cycle as a clear takes precedence
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     monitor_error <= 1'b0;
        else if (err_set) monitor_error <= 1'b1;
        else if (err_clr) monitor_error <= 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_nios_nios2_cpu_debug_mem_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_nios_nios2_cpu_debug_mem_sequencer
//  Description : Self-checking bench: vector table of debug commands against
//                a bus/result scoreboard, plus stall, timeout, pending-slot
//                and asynchronous-reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nios_nios2_cpu_debug_mem_sequencer;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 8;
    localparam int TMO_W   = 16;
    localparam int K_A = 0, K_N = 1, K_B = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        ta_a = 1'b0, tna_a = 1'b0, ta_b = 1'b0;
    logic [7:0]  mem_address;
    logic        mem_read, mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;
    logic        mem_waitrequest = 1'b0, mem_readdatavalid = 1'b0;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error, busy;

    always #5 clk = ~clk;

    nios_nios2_cpu_debug_mem_sequencer #(
        .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_no_action_ocimem_a(tna_a),
        .take_action_ocimem_b(ta_b),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest), .mem_readdatavalid(mem_readdatavalid),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready),
        .monitor_error(monitor_error), .busy(busy)
    );

    typedef struct packed { logic we; logic [7:0] addr; logic [31:0] data; } bus_t;
    typedef struct packed { logic [31:0] dreg; logic err; } res_t;
    typedef struct packed {
        int kind; logic [7:0] a; logic rd; logic clr; logic [31:0] d;
        logic [31:0] exp_dreg; logic [7:0] exp_addr; int exp_lat;
    } vec_t;

    int   n_cmp = 0, n_fail = 0;
    bus_t exp_bus[$];
    res_t exp_res[$];
    logic [31:0] slave_mem [256];
    logic [31:0] model_mem [256];
    logic [7:0]  model_addr = '0;
    logic [31:0] model_dreg = '0;
    logic        model_err = 1'b0;

    int   wait_cfg = 0, wcnt = 0, wr_high = 0, wr_accepts = 0;
    bit   no_resp = 0, rd_pend = 0;
    logic [31:0] rd_pend_data = '0;
    logic prev_ready = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // ocimem_a word, with junk in the fields this command ignores
    function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd, input logic clr);
        logic [37:0] j;
        j        = '0;
        j[16:3]  = 14'h2A5A;
        j[24:17] = a;
        j[32:25] = 8'hC3;
        j[33]    = clr;
        j[34]    = rd;
        j[37:35] = 3'b101;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j        = '0;
        j[34:3]  = d;
        j[37:35] = 3'b110;
        j[2:0]   = 3'b011;
        return j;
    endfunction

    // Reference model: updates expected state and queues bus/result expectations
    task automatic model_cmd(input int kind, input logic [7:0] a, input logic rd,
                             input logic clr, input logic [31:0] d);
        if (kind == K_A) begin
            model_addr = a;
            if (clr) model_err = 1'b0;
        end
        if ((kind == K_A && rd) || kind == K_N) begin
            exp_bus.push_back('{we: 1'b0, addr: model_addr, data: 32'h0});
            model_dreg = model_mem[model_addr];
            model_addr = model_addr + 8'd1;
            exp_res.push_back('{dreg: model_dreg, err: model_err});
        end else if (kind == K_B) begin
            exp_bus.push_back('{we: 1'b1, addr: model_addr, data: d});
            model_mem[model_addr] = d;
            model_addr = model_addr + 8'd1;
            exp_res.push_back('{dreg: model_dreg, err: model_err});
        end
    endtask

    task automatic strobe(input int kind, input logic [37:0] j);
        jdo   = j;
        ta_a  = (kind == K_A);
        tna_a = (kind == K_N);
        ta_b  = (kind == K_B);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while ((busy || !monitor_ready) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) begin
            n_cmp++; n_fail++;
            $display("FAIL op_wait: still busy after %0d cycles, required idle", lat);
        end
    endtask

    // Called at a negedge: one-cycle strobe, then cycles until idle+ready
    task automatic do_op(input int kind, input logic [37:0] j, output int lat);
        strobe(kind, j);
        @(negedge clk);
        strobe(K_A, '0); ta_a = 1'b0;
        wait_done(lat);
    endtask

    // Avalon slave: configurable wait states, read data one cycle after accept
    always @(negedge clk) begin
        if (rd_pend && !no_resp) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = rd_pend_data;
        end else begin
            mem_readdatavalid = 1'b0;
        end
        rd_pend = 0;
        if (mem_read || mem_write) begin
            if (mem_write) wr_high++;
            if (wcnt < wait_cfg) begin
                mem_waitrequest = 1'b1;
                wcnt++;
            end else begin
                mem_waitrequest = 1'b0;
                wcnt = 0;
                if (exp_bus.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL bus_unexpected: got we=%b addr=%h, required no access", mem_write, mem_address);
                end else begin
                    bus_t e;
                    e = exp_bus.pop_front();
                    check("bus_we", {31'd0, mem_write}, {31'd0, e.we});
                    check("bus_addr", {24'd0, mem_address}, {24'd0, e.addr});
                    if (mem_write) check("bus_wdata", mem_writedata, e.data);
                end
                if (mem_write) begin
                    slave_mem[mem_address] = mem_writedata;
                    wr_accepts++;
                end else begin
                    rd_pend      = 1;
                    rd_pend_data = slave_mem[mem_address];
                end
            end
        end else begin
            mem_waitrequest = 1'b0;
            wcnt = 0;
        end
    end

    // Result scoreboard: each rising monitor_ready completes the oldest command
    always @(negedge clk) begin
        if (reset_n && monitor_ready && !prev_ready) begin
            if (exp_res.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL ready_unexpected: got ready rise, required none");
            end else begin
                res_t r;
                r = exp_res.pop_front();
                check("done_mondreg", MonDReg, r.dreg);
                check("done_error", {31'd0, monitor_error}, {31'd0, r.err});
            end
        end
        prev_ready = monitor_ready;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    vec_t vecs[11];

    initial begin
        int lat, acc0;
        logic [37:0] j;

        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = pat(i);
            model_mem[i] = pat(i);
        end

        //                kind  a      rd    clr   d              exp_dreg       addr   lat
        vecs[0]  = '{K_A, 8'h10, 1'b0, 1'b0, 32'h0,         32'h0,         8'h10, 1};
        vecs[1]  = '{K_B, 8'h00, 1'b0, 1'b0, 32'hCAFEF00D,  32'h0,         8'h11, 2};
        vecs[2]  = '{K_A, 8'h10, 1'b1, 1'b0, 32'h0,         32'hCAFEF00D,  8'h11, 3};
        vecs[3]  = '{K_A, 8'hFF, 1'b0, 1'b0, 32'h0,         32'hCAFEF00D,  8'hFF, 1};
        vecs[4]  = '{K_B, 8'h00, 1'b0, 1'b0, 32'h12345678,  32'hCAFEF00D,  8'h00, 2};
        vecs[5]  = '{K_A, 8'hFF, 1'b0, 1'b0, 32'h0,         32'hCAFEF00D,  8'hFF, 1};
        vecs[6]  = '{K_N, 8'h00, 1'b0, 1'b0, 32'h0,         32'h12345678,  8'h00, 3};
        vecs[7]  = '{K_N, 8'h00, 1'b0, 1'b0, 32'h0,         32'hA5000000,  8'h01, 3};
        vecs[8]  = '{K_B, 8'h00, 1'b0, 1'b0, 32'hDEADBEEF,  32'hA5000000,  8'h02, 2};
        vecs[9]  = '{K_A, 8'h01, 1'b1, 1'b0, 32'h0,         32'hDEADBEEF,  8'h02, 3};
        vecs[10] = '{K_N, 8'h00, 1'b0, 1'b0, 32'h0,         32'hA5000002,  8'h03, 3};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_addr",   {24'd0, mem_address}, 32'h0);
        check("rst_mondreg", MonDReg, 32'h0);
        check("rst_ready",  {31'd0, monitor_ready}, 32'd1);
        check("rst_error",  {31'd0, monitor_error}, 32'd0);
        check("rst_read",   {31'd0, mem_read}, 32'd0);
        check("rst_write",  {31'd0, mem_write}, 32'd0);
        check("rst_wdata",  mem_writedata, 32'h0);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Vector table, zero-wait slave
        for (int v = 0; v < 11; v++) begin
            if (vecs[v].kind == K_B)      j = jdo_b(vecs[v].d);
            else if (vecs[v].kind == K_A) j = jdo_a(vecs[v].a, vecs[v].rd, vecs[v].clr);
            else                          j = jdo_a(8'h5C, 1'b1, 1'b1);
            model_cmd(vecs[v].kind, vecs[v].a, vecs[v].rd, vecs[v].clr, vecs[v].d);
            do_op(vecs[v].kind, j, lat);
            check($sformatf("vec%0d_addr", v), {24'd0, mem_address}, {24'd0, vecs[v].exp_addr});
            check($sformatf("vec%0d_dreg", v), MonDReg, vecs[v].exp_dreg);
            check($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
        end

        // Waitrequest stall: five wait states on a write
        wait_cfg = 5;
        model_cmd(K_A, 8'h20, 1'b0, 1'b0, 32'h0);
        do_op(K_A, jdo_a(8'h20, 1'b0, 1'b0), lat);
        wr_high = 0;
        acc0 = wr_accepts;
        model_cmd(K_B, 8'h00, 1'b0, 1'b0, 32'h55AA55AA);
        do_op(K_B, jdo_b(32'h55AA55AA), lat);
        check("stall_write_high", wr_high, 6);
        check("stall_accepts", wr_accepts - acc0, 1);
        check("stall_lat", lat, 7);
        check("stall_addr", {24'd0, mem_address}, 32'h21);
        wait_cfg = 0;

        // Timeout: read data never returns
        no_resp = 1;
        exp_bus.push_back('{we: 1'b0, addr: 8'h21, data: 32'h0});
        model_err = 1'b1;
        exp_res.push_back('{dreg: model_dreg, err: 1'b1});
        do_op(K_N, '0, lat);
        check("tmo_lat", lat, TIMEOUT + 1);
        check("tmo_error", {31'd0, monitor_error}, 32'd1);
        check("tmo_mondreg", MonDReg, 32'h55AA55AA & 32'h0 | model_dreg);
        check("tmo_addr", {24'd0, mem_address}, 32'h21);
        no_resp = 0;
        repeat (2) @(negedge clk);
        model_cmd(K_A, 8'h21, 1'b0, 1'b1, 32'h0);
        do_op(K_A, jdo_a(8'h21, 1'b0, 1'b1), lat);
        check("errclr_error", {31'd0, monitor_error}, 32'd0);

        // Pending slot and overflow during a stalled read; the third strobe
        // is dropped before the read completes, so both completions see error
        wait_cfg = 4;
        model_err = 1'b1;
        model_cmd(K_N, 8'h00, 1'b0, 1'b0, 32'h0);
        strobe(K_N, '0);
        @(negedge clk);
        model_cmd(K_B, 8'h00, 1'b0, 1'b0, 32'h11112222);
        strobe(K_B, jdo_b(32'h11112222));
        @(negedge clk);
        strobe(K_A, jdo_a(8'h50, 1'b1, 1'b0));
        @(negedge clk);
        strobe(K_A, '0); ta_a = 1'b0;
        wait_done(lat);
        check("pend_error", {31'd0, monitor_error}, 32'd1);
        check("pend_addr", {24'd0, mem_address}, 32'h23);
        check("pend_mondreg", MonDReg, pat(8'h21));
        check("pend_slave_mem", slave_mem[8'h22], 32'h11112222);
        wait_cfg = 0;
        model_cmd(K_A, 8'h23, 1'b0, 1'b1, 32'h0);
        do_op(K_A, jdo_a(8'h23, 1'b0, 1'b1), lat);
        check("pend_errclr", {31'd0, monitor_error}, 32'd0);
        check("queues_bus_empty", exp_bus.size(), 0);
        check("queues_res_empty", exp_res.size(), 0);

        // Asynchronous reset while waiting in RD_DATA
        no_resp = 1;
        model_cmd(K_N, 8'h00, 1'b0, 1'b0, 32'h0);
        strobe(K_N, '0);
        @(negedge clk);
        strobe(K_A, '0); ta_a = 1'b0;
        @(negedge clk);
        check("arst_pre_busy", {31'd0, busy}, 32'd1);
        check("arst_pre_ready", {31'd0, monitor_ready}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_read", {31'd0, mem_read}, 32'd0);
        check("arst_write", {31'd0, mem_write}, 32'd0);
        check("arst_ready", {31'd0, monitor_ready}, 32'd1);
        check("arst_addr", {24'd0, mem_address}, 32'h0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_mondreg", MonDReg, 32'h0);
        exp_res.delete();
        exp_bus.delete();
        rd_pend = 0;
        no_resp = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
